// File: rtl/data_sram_bridge_if.sv
// data_sram_bridge_if: SRAM-like request/ack bus between the data bridge (master) and memory (slave)
interface data_sram_bridge_if;
    logic        req_o;
    logic        wr_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        addr_ok_i;
    logic        data_ok_i;
    logic [31:0] rdata_i;
    modport master(output req_o, wr_o, be_o, addr_o, wdata_o, input addr_ok_i, data_ok_i, rdata_i);
    modport slave(input req_o, wr_o, be_o, addr_o, wdata_o, output addr_ok_i, data_ok_i, rdata_i);
endinterface

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns each memory-stage load/store into one SRAM-bus transaction, stalling until done
module data_sram_bridge #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_en_i,
    input  logic [3:0]         wen_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               stall_o,
    output logic               err_o,
    data_sram_bridge_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, err_q, start, fin, tmo;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    assign start = state_q == IDLE && mem_en_i;
    assign fin   = (state_q == REQ && bus.addr_ok_i && bus.data_ok_i) || (state_q == WAIT && bus.data_ok_i);
    assign tmo   = state_q == WAIT && !bus.data_ok_i && cnt_q + 8'd1 == TIMEOUT;
    assign cnt_d = state_q == WAIT ? cnt_q + 8'd1 : 8'd0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = mem_en_i ? REQ : IDLE;
            REQ:     state_d = bus.addr_ok_i ? (bus.data_ok_i ? DONE : WAIT) : REQ;
            WAIT:    state_d = (bus.data_ok_i || tmo) ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.req_o = state_q == REQ;
        stall_o   = mem_en_i && state_q != DONE;
    end
    // Request fields latch only on IDLE->REQ, so they stay put under back-pressure
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo;
            if (start) begin
                wr_q    <= |wen_i;
                be_q    <= |wen_i ? wen_i : 4'hF;
                addr_q  <= addr_i & ADDR_MASK;
                wdata_q <= wdata_i;
            end
            if (tmo)
                rdata_q <= '0;
            else if (fin && !wr_q)
                rdata_q <= bus.rdata_i;
        end
    assign bus.wr_o    = wr_q;
    assign bus.be_o    = be_q;
    assign bus.addr_o  = addr_q;
    assign bus.wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge: directed scenario tests for data_sram_bridge with hand-computed expectations
module tb_data_sram_bridge;
    logic        clk = 1'b0;
    logic        rst_n, mem_en_i;
    logic [3:0]  wen_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o, err_o;
    int          n_chk = 0, n_fail = 0;
    int          req_pulses = 0, req_cycles = 0;
    logic        req_prev = 1'b0;
    data_sram_bridge_if bus();
    data_sram_bridge #(.ADDR_MASK(32'h1FFF_FFFF), .TIMEOUT(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_en_i(mem_en_i), .wen_i(wen_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        req_pulses <= req_pulses + int'(bus.req_o && !req_prev);
        req_cycles <= req_cycles + int'(bus.req_o);
        req_prev   <= bus.req_o;
    end
    task automatic cyc;
        @(negedge clk);
    endtask
    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
        mem_en_i = en; wen_i = wen; addr_i = a; wdata_i = d;
    endtask
    task automatic ack(input logic aok, input logic dok, input logic [31:0] rd);
        bus.addr_ok_i = aok; bus.data_ok_i = dok; bus.rdata_i = rd;
    endtask
    task automatic test_reset;
        #3;
        if (bus.req_o !== 1'b0) begin $display("FAIL rst_req: got %b expected 0", bus.req_o); n_fail++; end n_chk++;
        if (bus.wr_o !== 1'b0) begin $display("FAIL rst_wr: got %b expected 0", bus.wr_o); n_fail++; end n_chk++;
        if (bus.be_o !== 4'h0) begin $display("FAIL rst_be: got %h expected 0", bus.be_o); n_fail++; end n_chk++;
        if (bus.addr_o !== 32'h0) begin $display("FAIL rst_addr: got %h expected 0", bus.addr_o); n_fail++; end n_chk++;
        if (bus.wdata_o !== 32'h0) begin $display("FAIL rst_wdata: got %h expected 0", bus.wdata_o); n_fail++; end n_chk++;
        if (rdata_o !== 32'h0) begin $display("FAIL rst_rdata: got %h expected 0", rdata_o); n_fail++; end n_chk++;
        if (err_o !== 1'b0) begin $display("FAIL rst_err: got %b expected 0", err_o); n_fail++; end n_chk++;
        if (stall_o !== 1'b0) begin $display("FAIL rst_stall_noen: got %b expected 0", stall_o); n_fail++; end n_chk++;
        mem_en_i = 1'b1; #1;
        if (stall_o !== 1'b1) begin $display("FAIL rst_stall_en: got %b expected 1", stall_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask
    task automatic test_load_zero_wait;
        int p0 = req_pulses;
        cyc(); drive(1'b1, 4'h0, 32'h8000_0010, 32'h0); #1;
        if (stall_o !== 1'b1) begin $display("FAIL ld_stall_idle: got %b expected 1", stall_o); n_fail++; end n_chk++;
        cyc(); ack(1'b1, 1'b1, 32'hCAFE_0001); #1;
        if (bus.req_o !== 1'b1) begin $display("FAIL ld_req: got %b expected 1", bus.req_o); n_fail++; end n_chk++;
        if (bus.addr_o !== 32'h0000_0010) begin $display("FAIL ld_addr: got %h expected 00000010", bus.addr_o); n_fail++; end n_chk++;
        if (bus.be_o !== 4'hF) begin $display("FAIL ld_be: got %h expected f", bus.be_o); n_fail++; end n_chk++;
        if (bus.wr_o !== 1'b0) begin $display("FAIL ld_wr: got %b expected 0", bus.wr_o); n_fail++; end n_chk++;
        if (stall_o !== 1'b1) begin $display("FAIL ld_stall_req: got %b expected 1", stall_o); n_fail++; end n_chk++;
        cyc(); ack(1'b0, 1'b0, 32'h0); #1;
        if (stall_o !== 1'b0) begin $display("FAIL ld_stall_done: got %b expected 0", stall_o); n_fail++; end n_chk++;
        if (rdata_o !== 32'hCAFE_0001) begin $display("FAIL ld_rdata: got %h expected cafe0001", rdata_o); n_fail++; end n_chk++;
        if (bus.req_o !== 1'b0) begin $display("FAIL ld_req_done: got %b expected 0", bus.req_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0;
        cyc(); #1;
        if (req_pulses - p0 !== 1) begin $display("FAIL ld_req_count: got %0d expected 1", req_pulses - p0); n_fail++; end n_chk++;
    endtask
    task automatic test_store_latency;
        int c0 = req_cycles;
        drive(1'b1, 4'b1000, 32'hA000_0003, 32'h5A00_0000); #1;
        if (stall_o !== 1'b1) begin $display("FAIL st_stall_idle: got %b expected 1", stall_o); n_fail++; end n_chk++;
        cyc(); ack(1'b1, 1'b0, 32'h0); #1;
        if (bus.addr_o !== 32'h0000_0003) begin $display("FAIL st_addr: got %h expected 00000003", bus.addr_o); n_fail++; end n_chk++;
        if (bus.be_o !== 4'b1000) begin $display("FAIL st_be: got %b expected 1000", bus.be_o); n_fail++; end n_chk++;
        if (bus.wr_o !== 1'b1) begin $display("FAIL st_wr: got %b expected 1", bus.wr_o); n_fail++; end n_chk++;
        if (bus.wdata_o !== 32'h5A00_0000) begin $display("FAIL st_wdata: got %h expected 5a000000", bus.wdata_o); n_fail++; end n_chk++;
        for (int i = 0; i < 3; i++) begin
            cyc(); ack(1'b0, i == 2, 32'hDEAD_BEEF); #1;
            if (bus.req_o !== 1'b0) begin $display("FAIL st_req_wait%0d: got %b expected 0", i, bus.req_o); n_fail++; end n_chk++;
            if (stall_o !== 1'b1) begin $display("FAIL st_stall_wait%0d: got %b expected 1", i, stall_o); n_fail++; end n_chk++;
        end
        cyc(); ack(1'b0, 1'b0, 32'h0); #1;
        if (stall_o !== 1'b0) begin $display("FAIL st_stall_done: got %b expected 0", stall_o); n_fail++; end n_chk++;
        if (rdata_o !== 32'hCAFE_0001) begin $display("FAIL st_rdata_kept: got %h expected cafe0001", rdata_o); n_fail++; end n_chk++;
        if (err_o !== 1'b0) begin $display("FAIL st_err: got %b expected 0", err_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0;
        cyc(); #1;
        if (req_cycles - c0 !== 1) begin $display("FAIL st_req_cycles: got %0d expected 1", req_cycles - c0); n_fail++; end n_chk++;
    endtask
    task automatic test_back_to_back;
        int p0 = req_pulses;
        drive(1'b1, 4'h0, 32'h8000_0100, 32'h0);
        cyc(); ack(1'b1, 1'b1, 32'h1111_2222);
        cyc(); ack(1'b0, 1'b0, 32'h0); #1;
        if (rdata_o !== 32'h1111_2222) begin $display("FAIL b2b_ld_rdata: got %h expected 11112222", rdata_o); n_fail++; end n_chk++;
        if (stall_o !== 1'b0) begin $display("FAIL b2b_ld_stall: got %b expected 0", stall_o); n_fail++; end n_chk++;
        if (bus.req_o !== 1'b0) begin $display("FAIL b2b_done_req: got %b expected 0", bus.req_o); n_fail++; end n_chk++;
        cyc(); drive(1'b1, 4'b0011, 32'h0000_0204, 32'h0000_BEEF); #1;
        if (stall_o !== 1'b1) begin $display("FAIL b2b_st_stall: got %b expected 1", stall_o); n_fail++; end n_chk++;
        cyc(); ack(1'b1, 1'b1, 32'h7777_7777); #1;
        if (bus.req_o !== 1'b1) begin $display("FAIL b2b_st_req: got %b expected 1", bus.req_o); n_fail++; end n_chk++;
        if (bus.addr_o !== 32'h0000_0204) begin $display("FAIL b2b_st_addr: got %h expected 00000204", bus.addr_o); n_fail++; end n_chk++;
        if (bus.be_o !== 4'b0011) begin $display("FAIL b2b_st_be: got %b expected 0011", bus.be_o); n_fail++; end n_chk++;
        if (bus.wr_o !== 1'b1) begin $display("FAIL b2b_st_wr: got %b expected 1", bus.wr_o); n_fail++; end n_chk++;
        if (bus.wdata_o !== 32'h0000_BEEF) begin $display("FAIL b2b_st_wdata: got %h expected 0000beef", bus.wdata_o); n_fail++; end n_chk++;
        cyc(); ack(1'b0, 1'b0, 32'h0); #1;
        if (rdata_o !== 32'h1111_2222) begin $display("FAIL b2b_st_rdata: got %h expected 11112222", rdata_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0;
        cyc(); cyc(); #1;
        if (req_pulses - p0 !== 2) begin $display("FAIL b2b_req_count: got %0d expected 2", req_pulses - p0); n_fail++; end n_chk++;
    endtask
    task automatic test_timeout;
        drive(1'b1, 4'h0, 32'h8000_0020, 32'h0);
        cyc(); ack(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(); ack(1'b0, 1'b0, 32'h0); #1;
            if (stall_o !== 1'b1) begin $display("FAIL to_stall_wait%0d: got %b expected 1", i, stall_o); n_fail++; end n_chk++;
            if (err_o !== 1'b0) begin $display("FAIL to_err_wait%0d: got %b expected 0", i, err_o); n_fail++; end n_chk++;
        end
        cyc(); #1;
        if (err_o !== 1'b1) begin $display("FAIL to_err: got %b expected 1", err_o); n_fail++; end n_chk++;
        if (rdata_o !== 32'h0) begin $display("FAIL to_rdata: got %h expected 0", rdata_o); n_fail++; end n_chk++;
        if (stall_o !== 1'b0) begin $display("FAIL to_stall: got %b expected 0", stall_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0;
        cyc(); #1;
        if (err_o !== 1'b0) begin $display("FAIL to_err_pulse: got %b expected 0", err_o); n_fail++; end n_chk++;
        drive(1'b1, 4'h0, 32'h8000_0030, 32'h0);
        cyc(); ack(1'b1, 1'b1, 32'h1234_5678);
        cyc(); ack(1'b0, 1'b0, 32'h0); #1;
        if (rdata_o !== 32'h1234_5678) begin $display("FAIL to_next_rdata: got %h expected 12345678", rdata_o); n_fail++; end n_chk++;
        if (err_o !== 1'b0) begin $display("FAIL to_next_err: got %b expected 0", err_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0;
        cyc();
    endtask
    task automatic test_async_reset;
        int p0;
        drive(1'b1, 4'h0, 32'h8000_0040, 32'h0);
        cyc(); ack(1'b1, 1'b0, 32'h0);
        cyc(); ack(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0; #1;
        if (rdata_o !== 32'h0) begin $display("FAIL ar_rdata: got %h expected 0", rdata_o); n_fail++; end n_chk++;
        if (bus.req_o !== 1'b0) begin $display("FAIL ar_req: got %b expected 0", bus.req_o); n_fail++; end n_chk++;
        if (bus.addr_o !== 32'h0) begin $display("FAIL ar_addr: got %h expected 0", bus.addr_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0; #1;
        if (stall_o !== 1'b0) begin $display("FAIL ar_stall: got %b expected 0", stall_o); n_fail++; end n_chk++;
        cyc(); rst_n = 1'b1;
        p0 = req_pulses;
        for (int i = 0; i < 3; i++) begin
            cyc(); ack(1'b1, 1'b1, 32'hBAD0_0000 + 32'(i)); #1;
            if (stall_o !== 1'b0) begin $display("FAIL ar_idle_stall%0d: got %b expected 0", i, stall_o); n_fail++; end n_chk++;
        end
        cyc(); ack(1'b0, 1'b0, 32'h0); #1;
        if (rdata_o !== 32'h0) begin $display("FAIL ar_stale_rdata: got %h expected 0", rdata_o); n_fail++; end n_chk++;
        if (req_pulses - p0 !== 0) begin $display("FAIL ar_req_count: got %0d expected 0", req_pulses - p0); n_fail++; end n_chk++;
    endtask
    task automatic test_backpressure;
        drive(1'b1, 4'hF, 32'h9000_0040, 32'h0BAD_F00D);
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc(); drive(1'b1, 4'(i), 32'hFFFF_FF00 + 32'(i), 32'h1357_0000 + 32'(i)); ack(1'b0, i[0], 32'hEEEE_EEEE); #1;
            if (bus.req_o !== 1'b1) begin $display("FAIL bp_req%0d: got %b expected 1", i, bus.req_o); n_fail++; end n_chk++;
            if (bus.addr_o !== 32'h1000_0040) begin $display("FAIL bp_addr%0d: got %h expected 10000040", i, bus.addr_o); n_fail++; end n_chk++;
            if (bus.be_o !== 4'hF) begin $display("FAIL bp_be%0d: got %h expected f", i, bus.be_o); n_fail++; end n_chk++;
            if (bus.wdata_o !== 32'h0BAD_F00D) begin $display("FAIL bp_wdata%0d: got %h expected 0badf00d", i, bus.wdata_o); n_fail++; end n_chk++;
            if (stall_o !== 1'b1) begin $display("FAIL bp_stall%0d: got %b expected 1", i, stall_o); n_fail++; end n_chk++;
        end
        cyc(); ack(1'b1, 1'b1, 32'hEEEE_EEEE);
        cyc(); ack(1'b0, 1'b0, 32'h0); #1;
        if (stall_o !== 1'b0) begin $display("FAIL bp_stall_done: got %b expected 0", stall_o); n_fail++; end n_chk++;
        if (rdata_o !== 32'h0) begin $display("FAIL bp_rdata: got %h expected 0", rdata_o); n_fail++; end n_chk++;
        mem_en_i = 1'b0;
        cyc();
    endtask
    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        ack(1'b0, 1'b0, 32'h0);
        test_reset();
        cyc();
        test_load_zero_wait();
        test_store_latency();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
